// File: rtl/cc_level_sequencer.sv
// Per-player level row sequencer: LFSR-generated one-hot lane rows over valid/ready, with done/error pulses.
// Optional macro CC_LEVEL_SEQUENCER_DUAL_LANE_EN adds a second hazard per row for levels 2 and up.
module cc_level_sequencer #(
  parameter int          DATAWIDTH      = 8,
  parameter int          LEVEL_WIDTH    = 3,
  parameter int          NUM_LEVELS     = 3,
  parameter int          PROGRESS_WIDTH = 5,
  parameter int          BASE_LEN       = 10,
  parameter int          LEN_STEP       = 5,
  parameter logic [7:0]  SEED           = 8'hA5
) (
  input  logic                      CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic                      CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic                      CC_LEVEL_SEQUENCER_Start_In,
  input  logic [LEVEL_WIDTH-1:0]    CC_LEVEL_SEQUENCER_Level_In,
  input  logic                      CC_LEVEL_SEQUENCER_Abort_In,
  input  logic                      CC_LEVEL_SEQUENCER_Ready_In,
  output logic [DATAWIDTH-1:0]      CC_LEVEL_SEQUENCER_LevelData_OutBus,
  output logic                      CC_LEVEL_SEQUENCER_Valid_Out,
  output logic [PROGRESS_WIDTH-1:0] CC_LEVEL_SEQUENCER_Progress_Out,
  output logic                      CC_LEVEL_SEQUENCER_Done_Out,
  output logic                      CC_LEVEL_SEQUENCER_Err_Out
);

  localparam int LANE_W = $clog2(DATAWIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                    state_q, state_d;
  logic [7:0]                lfsr_q, lfsr_d;
  logic [PROGRESS_WIDTH-1:0] len_q, len_d;
  logic [PROGRESS_WIDTH-1:0] progress_q, progress_d;
  logic [DATAWIDTH-1:0]      data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      start_req;
  logic                      start_ok;
  logic [PROGRESS_WIDTH-1:0] start_len;
  logic [7:0]                start_seed;
  logic                      start_dual;
  logic                      run_dual;

  // The register must never sit at zero, where the Fibonacci map would lock up.
  function automatic logic [7:0] lfsr_fix(input logic [7:0] l);
    return (l == 8'h00) ? SEED : l;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return lfsr_fix({l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]});
  endfunction

  function automatic logic [DATAWIDTH-1:0] row_of(input logic [7:0] l, input logic dual);
    logic [LANE_W-1:0]    lane;
    logic [LANE_W-1:0]    lane2;
    logic [DATAWIDTH-1:0] r;
    lane  = l[LANE_W-1:0];
    lane2 = lane + LANE_W'(DATAWIDTH / 2);
    r = '0;
    r[lane] = 1'b1;
    if (dual) r[lane2] = 1'b1;
    return r;
  endfunction

  // Abort in IDLE also suppresses a coincident start (and its error pulse).
  assign start_req  = CC_LEVEL_SEQUENCER_Start_In && !CC_LEVEL_SEQUENCER_Abort_In;
  assign start_ok   = (CC_LEVEL_SEQUENCER_Level_In != '0) &&
                      (CC_LEVEL_SEQUENCER_Level_In <= LEVEL_WIDTH'(NUM_LEVELS));
  assign start_len  = PROGRESS_WIDTH'(BASE_LEN + (int'(CC_LEVEL_SEQUENCER_Level_In) - 1) * LEN_STEP);
  assign start_seed = lfsr_fix(SEED ^ 8'(CC_LEVEL_SEQUENCER_Level_In));

`ifdef CC_LEVEL_SEQUENCER_DUAL_LANE_EN
  logic dual_q, dual_d;

  assign start_dual = (CC_LEVEL_SEQUENCER_Level_In >= LEVEL_WIDTH'(2));
  assign run_dual   = dual_q;
  assign dual_d     = (state_q == ST_IDLE && start_req && start_ok) ? start_dual : dual_q;

  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      dual_q <= 1'b0;
    end else begin
      dual_q <= dual_d;
    end
  end
`else
  assign start_dual = 1'b0;
  assign run_dual   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    len_d      = len_q;
    progress_d = progress_q;
    data_d     = data_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (start_ok) begin
            state_d    = ST_RUN;
            lfsr_d     = start_seed;
            len_d      = start_len;
            progress_d = PROGRESS_WIDTH'(1);
            data_d     = row_of(start_seed, start_dual);
            valid_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (CC_LEVEL_SEQUENCER_Abort_In) begin
          state_d    = ST_IDLE;
          progress_d = '0;
          data_d     = '0;
          valid_d    = 1'b0;
        end else if (CC_LEVEL_SEQUENCER_Ready_In) begin
          if (progress_q == len_q) begin
            state_d    = ST_DONE;
            progress_d = '0;
            data_d     = '0;
            valid_d    = 1'b0;
            done_d     = 1'b1;
          end else begin
            lfsr_d     = lfsr_step(lfsr_q);
            progress_d = progress_q + PROGRESS_WIDTH'(1);
            data_d     = row_of(lfsr_step(lfsr_q), run_dual);
          end
        end
      end

      ST_DONE: begin
        // Outputs were already cleared on entry; this cycle only carries the Done pulse.
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        progress_d = '0;
        data_d     = '0;
        valid_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      len_q      <= '0;
      progress_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      len_q      <= len_d;
      progress_q <= progress_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign CC_LEVEL_SEQUENCER_LevelData_OutBus = data_q;
  assign CC_LEVEL_SEQUENCER_Valid_Out        = valid_q;
  assign CC_LEVEL_SEQUENCER_Progress_Out     = progress_q;
  assign CC_LEVEL_SEQUENCER_Done_Out         = done_q;
  assign CC_LEVEL_SEQUENCER_Err_Out          = err_q;

endmodule

// File: doc/cc_level_sequencer.md
Name: cc_level_sequencer

Overview:
Parametrised, sequential successor to the per-player level data handler. On a start command it generates the lane-pattern rows for the selected level, keeping its own progress counter. Rows come from an internal LFSR instead of hard-coded tables. Each row goes to the lane/obstacle logic over a valid/ready handshake, and the block signals end of level; one instance per player.

Parameters:
DATAWIDTH, 8, row width in bits (power of 2, ≥4); one bit per lane
LEVEL_WIDTH, 3, width of level select input
NUM_LEVELS, 3, number of valid levels (1..NUM_LEVELS)
PROGRESS_WIDTH, 5, width of progress counter
BASE_LEN, 10, rows in level 1
LEN_STEP, 5, extra rows per level above 1 (level L length = BASE_LEN+(L-1)*LEN_STEP); BASE_LEN+(NUM_LEVELS-1)*LEN_STEP ≤ 2^PROGRESS_WIDTH-1
SEED, 8'hA5, LFSR base seed

Ports:
CC_LEVEL_SEQUENCER_CLOCK_50  in  1  system clock, all logic on rising edge
CC_LEVEL_SEQUENCER_RESET_InLow  in  1  synchronous, active-low reset
CC_LEVEL_SEQUENCER_Start_In  in  1  start request for the level on Level_In (sampled in IDLE only)
CC_LEVEL_SEQUENCER_Level_In  in  LEVEL_WIDTH  level select
CC_LEVEL_SEQUENCER_Abort_In  in  1  abandon current level (player death/reset of game)
CC_LEVEL_SEQUENCER_Ready_In  in  1  consumer accepts current row
CC_LEVEL_SEQUENCER_LevelData_OutBus  out  DATAWIDTH  current row pattern (registered)
CC_LEVEL_SEQUENCER_Valid_Out  out  1  row on OutBus valid
CC_LEVEL_SEQUENCER_Progress_Out  out  PROGRESS_WIDTH  1-based index of current row; 0 when idle
CC_LEVEL_SEQUENCER_Done_Out  out  1  one-cycle pulse: last row of level accepted
CC_LEVEL_SEQUENCER_Err_Out  out  1  one-cycle pulse: start with invalid level

Behaviour:
- Reset (RESET_InLow=0 at a clock edge): state IDLE; OutBus=0, Valid=0, Progress=0, Done=0, Err=0, LFSR=SEED. Reset has priority over every other input, including mid-level.
- States: IDLE, RUN, DONE.
- IDLE: Valid=0, OutBus=0, Progress=0.
  - Start=1 with 1≤Level_In≤NUM_LEVELS: next cycle enter RUN; LFSR=SEED^Level_In (zero-extended); latch level and length; Progress=1; OutBus=row(LFSR seed); Valid=1.
  - Start=1 with Level_In=0 or >NUM_LEVELS: Err=1 for one cycle; stay IDLE.
- RUN: Valid=1; OutBus and Progress held stable while Ready=0.
  - Valid&Ready with Progress<length: LFSR steps once; OutBus=row(new LFSR); Progress+1; both visible next cycle. Zero-bubble: back-to-back accepts give one row per clock.
  - Valid&Ready with Progress==length: go to DONE; Valid=0, OutBus=0.
  - Start ignored in RUN.
- DONE (one cycle): Done=1, Progress=0; then IDLE.
- Abort=1 in RUN or DONE: next cycle IDLE, Valid=0, OutBus=0, Progress=0, no Done pulse. Abort beats a simultaneous accept. Abort in IDLE has no effect, but Start in the same cycle is ignored.
- LFSR: 8-bit Fibonacci. new=l[7]^l[5]^l[4]^l[3]; l={l[6:0],new}. All-zero state is forced to SEED.
- row(l): lane=l[log2(DATAWIDTH)-1:0]; OutBus = 1<<lane (one-hot).
- Counter never wraps: the length constraint guarantees Progress fits.

Optional Feature:
Macro CC_LEVEL_SEQUENCER_DUAL_LANE_EN.
- Defined: for latched level ≥2, row(l) = (1<<lane) | (1<<((lane+DATAWIDTH/2) mod DATAWIDTH)), i.e. two hazards per row. Level 1 stays one-hot.
- Undefined: rows are always one-hot; no extra logic is synthesised.

Test Plan:
- Reset: hold RESET_InLow=0 for 2 clocks with Start=1 -> OutBus=0, Valid=0, Progress=0, Done=0, Err=0.
- Start level 1, Ready=1 -> Valid rises 1 cycle after start; first OutBus=8'b00010000 (LFSR 8'hA4, lane 4), second 8'b00000001 (LFSR 8'h48). Exactly 10 accepted rows, Progress 1..10, Done pulse on the cycle after the 10th accept.
- Start level 3, Ready toggled 1/0 each cycle -> OutBus/Progress stable while Ready=0; exactly 20 accepted rows, then one Done pulse.
- Start with Level_In=0, then Level_In=4 -> one Err pulse each, Valid stays 0, state IDLE.
- Level 2 running, Abort=1 together with Ready=1 at Progress=5 -> next cycle Valid=0, Progress=0, no Done pulse. A new Start level 2 then restarts at Progress=1 with OutBus for LFSR 8'hA7 (8'b10000000).
- With DUAL_LANE_EN, level 2 first row (lane 7) -> OutBus=8'b10001000; level 1 first row unchanged 8'b00010000.
